// File: rtl/ws2812b_pkg.sv
// Shared constants and state encoding for the WS2812B pixel serializer.
package ws2812b_pkg;

    localparam int unsigned BIT_PERIOD_DEFAULT     = 63;
    localparam int unsigned LATCH_DEFAULT          = 2800;
    localparam int unsigned BITS_PER_PIXEL_DEFAULT = 24;
    localparam int unsigned T0H_CLK_COUNTS         = 19;
    localparam int unsigned T1H_CLK_COUNTS         = 39;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    // Counter width for a modulus; never zero so single-count builds still elaborate.
    function automatic int unsigned cnt_width(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/pixel_skid_buffer.sv
// One-entry pixel holding register; a write in the same cycle as a read wins.
module pixel_skid_buffer #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_last,
    input  logic             rd_en,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             last
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (rd_en) begin
            valid_d = 1'b0;
        end
        if (wr_en) begin
            valid_d = 1'b1;
            data_d  = wr_data;
            last_d  = wr_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign last  = last_q;

endmodule

// File: rtl/ws2812b_pixel_serializer.sv
// Turns a valid/ready GRB pixel stream into MSB-first trigger/bit pulses for the NRZ stage.
//   state | meaning
//   IDLE  | waiting for the first pixel of a frame
//   SHIFT | emitting one trigger per bit period
//   LATCH | trigger-free hold-off so the strip latches
module ws2812b_pixel_serializer
    import ws2812b_pkg::*;
#(
    parameter int unsigned BIT_PERIOD_CLK_COUNTS = BIT_PERIOD_DEFAULT,
    parameter int unsigned LATCH_CLK_COUNTS      = LATCH_DEFAULT,
    parameter int unsigned BITS_PER_PIXEL        = BITS_PER_PIXEL_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [BITS_PER_PIXEL-1:0] pixel_data,
    input  logic                      pixel_valid,
    input  logic                      pixel_last,
    output logic                      pixel_ready,
    output logic                      trigger,
    output logic                      bit_to_code,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      underrun
);

    localparam int unsigned PER_W = cnt_width(BIT_PERIOD_CLK_COUNTS);
    localparam int unsigned LAT_W = cnt_width(LATCH_CLK_COUNTS);
    localparam int unsigned IDX_W = cnt_width(BITS_PER_PIXEL);
    localparam int unsigned MSB   = BITS_PER_PIXEL - 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(BIT_PERIOD_CLK_COUNTS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CLK_COUNTS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_PER_PIXEL - 1);

    state_e                    state_q, state_d;
    logic [PER_W-1:0]          per_cnt_q, per_cnt_d;
    logic [LAT_W-1:0]          lat_cnt_q, lat_cnt_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
    logic                      cur_last_q, cur_last_d;
    logic                      last_seen_q, last_seen_d;
    logic                      bit_hold_q, bit_hold_d;
    logic                      frame_done_q, frame_done_d;
    logic                      rdy_en_q, rdy_en_d;

    logic                      accept, bit_end, pixel_end, lat_end, direct_load;
    logic                      buf_valid, buf_last, buf_wr, buf_rd;
    logic [BITS_PER_PIXEL-1:0] buf_data;

    assign accept    = pixel_valid && pixel_ready;
    assign bit_end   = (state_q == SHIFT) && (per_cnt_q == PER_LAST);
    assign pixel_end = bit_end && (bit_idx_q == IDX_LAST);
    assign lat_end   = (state_q == LATCH) && (lat_cnt_q == LAT_LAST);

    // An empty buffer at the boundary lets a same-cycle accept go straight to the shifter.
    assign direct_load = accept && ((state_q == IDLE) || (pixel_end && !buf_valid && !cur_last_q));
    assign buf_rd      = pixel_end && !cur_last_q && buf_valid;
    assign buf_wr      = accept && !direct_load;

    pixel_skid_buffer #(.WIDTH(BITS_PER_PIXEL)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (buf_wr),
        .wr_data (pixel_data),
        .wr_last (pixel_last),
        .rd_en   (buf_rd),
        .valid   (buf_valid),
        .data    (buf_data),
        .last    (buf_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            per_cnt_q    <= '0;
            lat_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            cur_last_q   <= 1'b0;
            last_seen_q  <= 1'b0;
            bit_hold_q   <= 1'b0;
            frame_done_q <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            cur_last_q   <= cur_last_d;
            last_seen_q  <= last_seen_d;
            bit_hold_q   <= bit_hold_d;
            frame_done_q <= frame_done_d;
            rdy_en_q     <= rdy_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (pixel_end && (cur_last_q || !(buf_valid || accept))) state_d = LATCH;
            LATCH:   if (lat_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        per_cnt_d    = per_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        cur_last_d   = cur_last_q;
        last_seen_d  = last_seen_q;
        bit_hold_d   = bit_hold_q;
        frame_done_d = lat_end;
        rdy_en_d     = 1'b1;

        if (state_q == SHIFT) begin
            per_cnt_d = bit_end ? '0 : per_cnt_q + 1'b1;
            lat_cnt_d = '0;
            if (bit_end) begin
                shift_d   = shift_q << 1;
                bit_idx_d = pixel_end ? '0 : bit_idx_q + 1'b1;
            end
        end
        if (state_q == LATCH) begin
            lat_cnt_d = lat_end ? '0 : lat_cnt_q + 1'b1;
        end
        if (buf_rd) begin
            shift_d    = buf_data;
            cur_last_d = buf_last;
        end
        if (direct_load) begin
            shift_d    = pixel_data;
            cur_last_d = pixel_last;
            per_cnt_d  = '0;
            bit_idx_d  = '0;
        end
        if (trigger) begin
            bit_hold_d = shift_q[MSB];
        end
        if (lat_end) begin
            last_seen_d = 1'b0;
        end
        if (accept && pixel_last) begin
            last_seen_d = 1'b1;
        end
    end

    always_comb begin
        trigger     = (state_q == SHIFT) && (per_cnt_q == '0);
        busy        = (state_q != IDLE);
        bit_to_code = (state_q == SHIFT) ? shift_q[MSB] : bit_hold_q;
    end

    // Ready stays low in the frame_done cycle so the next frame starts one cycle later.
    assign pixel_ready = rdy_en_q && !buf_valid && (state_q != LATCH) && !last_seen_q && !frame_done_q;
    assign underrun    = pixel_end && !cur_last_q && !buf_valid && !accept;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ws2812b_pixel_serializer.sv
// Directed bench: default-parameter DUT for frame timing, small-parameter DUT for an exact trace.
module tb_ws2812b_pixel_serializer;

    localparam int BP  = 63;
    localparam int LT  = 2800;
    localparam int PIX = 24 * BP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n     = 1'b0;
    logic [23:0] pixel_data  = '0;
    logic        pixel_valid = 1'b0;
    logic        pixel_last  = 1'b0;
    logic        pixel_ready, trigger, bit_to_code, busy, frame_done, underrun;

    logic [3:0]  s_data  = '0;
    logic        s_valid = 1'b0;
    logic        s_last  = 1'b0;
    logic        s_ready, s_trigger, s_bit, s_busy, s_done, s_underrun;

    ws2812b_pixel_serializer dut (
        .clk(clk), .reset_n(reset_n), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .pixel_last(pixel_last), .pixel_ready(pixel_ready), .trigger(trigger),
        .bit_to_code(bit_to_code), .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    ws2812b_pixel_serializer #(
        .BIT_PERIOD_CLK_COUNTS(4), .LATCH_CLK_COUNTS(5), .BITS_PER_PIXEL(4)
    ) dut_small (
        .clk(clk), .reset_n(reset_n), .pixel_data(s_data), .pixel_valid(s_valid),
        .pixel_last(s_last), .pixel_ready(s_ready), .trigger(s_trigger),
        .bit_to_code(s_bit), .busy(s_busy), .frame_done(s_done), .underrun(s_underrun)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int   trig_t[$];
    logic trig_b[$];
    int   fd_t[$];
    int   ur_t[$];
    logic rdy_fd[$];
    logic rdy_after[$];
    logic fd_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (trigger) begin
            trig_t.push_back(cyc);
            trig_b.push_back(bit_to_code);
        end
        if (underrun) ur_t.push_back(cyc);
        if (frame_done) begin
            fd_t.push_back(cyc);
            rdy_fd.push_back(pixel_ready);
        end
        if (fd_prev) rdy_after.push_back(pixel_ready);
        fd_prev = frame_done;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        trig_t.delete(); trig_b.delete(); fd_t.delete();
        ur_t.delete(); rdy_fd.delete(); rdy_after.delete();
    endtask

    // Offers a pixel and returns at the negedge after the accepting edge (the first-trigger cycle).
    task automatic send(input logic [23:0] d, input logic l, input int limit,
                        output int waited, output int t_first);
        int n = 0;
        pixel_data  = d;
        pixel_last  = l;
        pixel_valid = 1'b1;
        while (!pixel_ready && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 64'(n < limit), 64'd1);
        @(negedge clk);
        waited  = n;
        t_first = cyc;
    endtask

    function automatic int spacing_errs(input int from, input int to);
        int e = 0;
        for (int i = from + 1; i <= to; i++) begin
            if (i >= trig_t.size() || trig_t[i] - trig_t[i-1] != BP) e++;
        end
        return e;
    endfunction

    function automatic logic [23:0] word_at(input int base);
        logic [23:0] w = '0;
        for (int i = 0; i < 24; i++) begin
            w = {w[22:0], (base + i < trig_b.size()) ? trig_b[base + i] : 1'b0};
        end
        return w;
    endfunction

    initial begin
        int   w, t0, k, n;
        logic [7:0] s_seq;
        logic e_trig, e_bit, e_ready, e_busy, e_done;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_outputs", {pixel_ready, trigger, bit_to_code, busy, frame_done, underrun}, 6'b0);
        check("rst_small_ready", 64'(s_ready), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready_after_release", 64'(pixel_ready), 64'd1);

        // small build: A=1011 (not last), B=0110 (last) offered exactly at A's boundary
        s_seq   = 8'b1011_0110;
        s_data  = 4'b1011;
        s_last  = 1'b0;
        s_valid = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1)  s_valid = 1'b0;
            if (i == 16) begin s_valid = 1'b1; s_data = 4'b0110; s_last = 1'b1; end
            if (i == 17) s_valid = 1'b0;
            #1;
            e_trig  = (i <= 29) && ((i - 1) % 4 == 0);
            e_bit   = (i <= 32) ? s_seq[7 - (i - 1) / 4] : 1'b0;
            e_ready = (i <= 16) || (i >= 39);
            e_busy  = (i <= 37);
            e_done  = (i == 38);
            check($sformatf("small_cyc%0d", i),
                  {s_trigger, s_bit, s_busy, s_done, s_underrun, s_ready},
                  {e_trig, e_bit, e_busy, e_done, 1'b0, e_ready});
        end

        // single pixel frame
        @(negedge clk);
        clr();
        send(24'hA500FF, 1'b1, 10, w, t0);
        pixel_valid = 1'b0;
        check("t1_busy", 64'(busy), 64'd1);
        repeat (PIX + LT + 10) @(negedge clk);
        check("t1_trig_count", trig_t.size(), 24);
        check("t1_first_trig", trig_t[0], t0);
        check("t1_spacing", spacing_errs(0, 23), 0);
        check("t1_bits", word_at(0), 24'hA500FF);
        check("t1_fd_count", fd_t.size(), 1);
        check("t1_fd_delay", fd_t[0] - trig_t[23], BP + LT);
        check("t1_rdy_at_fd", 64'(rdy_fd[0]), 64'd0);
        check("t1_rdy_after_fd", 64'(rdy_after[0]), 64'd1);
        check("t1_underruns", ur_t.size(), 0);
        check("t1_idle", {busy, pixel_ready}, 2'b01);

        // three back-to-back pixels
        clr();
        send(24'h123456, 1'b0, 10, w, t0);
        send(24'hFEDCBA, 1'b0, 10, w, k);
        check("t2_p1_wait", w, 0);
        send(24'h0F0F0F, 1'b1, 3000, w, k);
        check("t2_p2_wait_buffer_full", w, PIX - 1);
        pixel_valid = 1'b0;
        repeat (2 * PIX + LT + 10) @(negedge clk);
        check("t2_trig_count", trig_t.size(), 72);
        check("t2_first_trig", trig_t[0], t0);
        check("t2_spacing", spacing_errs(0, 71), 0);
        check("t2_px0", word_at(0), 24'h123456);
        check("t2_px1", word_at(24), 24'hFEDCBA);
        check("t2_px2", word_at(48), 24'h0F0F0F);
        check("t2_underruns", ur_t.size(), 0);
        check("t2_fd_count", fd_t.size(), 1);
        check("t2_fd_delay", fd_t[0] - trig_t[71], BP + LT);

        // late second pixel: underrun, stalled through LATCH, new frame after frame_done
        clr();
        send(24'h000001, 1'b0, 10, w, t0);
        pixel_valid = 1'b0;
        repeat (PIX) @(negedge clk);
        send(24'h800000, 1'b1, 4000, w, k);
        check("t3_stall_cycles", w, LT + 1);
        pixel_valid = 1'b0;
        repeat (PIX + LT + 10) @(negedge clk);
        check("t3_trig_count", trig_t.size(), 48);
        check("t3_underruns", ur_t.size(), 1);
        check("t3_underrun_time", ur_t[0] - trig_t[23], BP - 1);
        check("t3_fd_count", fd_t.size(), 2);
        check("t3_fd_delay", fd_t[0] - trig_t[23], BP + LT);
        check("t3_next_frame_start", trig_t[24] - fd_t[0], 2);
        check("t3_first_frame_bits", word_at(0), 24'h000001);
        check("t3_second_frame_bits", word_at(24), 24'h800000);
        check("t3_spacing2", spacing_errs(24, 47), 0);

        // reset at trigger #10
        clr();
        send(24'hFFFFFF, 1'b1, 10, w, t0);
        pixel_valid = 1'b0;
        k = 1;
        n = 0;
        while (k < 10 && n < 1000) begin
            @(negedge clk);
            n++;
            if (trigger) k++;
        end
        check("t5_reached_trig10", k, 10);
        reset_n = 1'b0;
        @(negedge clk);
        check("t5_rst_outputs", {pixel_ready, trigger, bit_to_code, busy, frame_done, underrun}, 6'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check("t5_ready_after_release", 64'(pixel_ready), 64'd1);
        repeat (PIX + LT) @(negedge clk);
        check("t5_trig_count", trig_t.size(), 10);
        check("t5_no_frame_done", fd_t.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
